sr_pulse_decoder: RTL and testbench

SR_PULSE_DECODER -- requirements
Module: sr_pulse_decoder

---
 rtl/sr_pulse_decoder.sv | 115 +++++++++++
 tb/tb_sr_pulse_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_decoder.sv
// Strobe-qualified SR latch decoder: synchronizes an async pulse line, edge-detects it,
// and applies S/R commands with strobe counting, illegal-command trapping and idle timeout.
module sr_pulse_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ppulse,
  input  logic             S,
  input  logic             R,
  input  logic             clr_err,
  output logic             Q,
  output logic             Qbar,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             err_illegal,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, RUN, TMO, ERR} state_t;

  localparam logic [7:0] TMO_LIM = TIMEOUT[7:0];

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   strobe;
  state_t                 state_q, state_d;
  logic                   q_q, q_d;
  logic [CNT_W-1:0]       pulse_cnt_q, pulse_cnt_d;
  logic                   err_q, err_d;
  logic                   tmo_q, tmo_d;
  logic [7:0]             idle_q, idle_d;
  logic                   legal, illegal;

  assign strobe  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign illegal = strobe & S & R;
  assign legal   = strobe & ~(S & R);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], ppulse};
    prev_d      = sync_q[SYNC_STAGES-1];
    state_d     = state_q;
    q_d         = q_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    idle_d      = idle_q;
    pulse_cnt_d = pulse_cnt_q;

    if (strobe) pulse_cnt_d = pulse_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE, RUN, TMO: begin
        if (illegal) begin
          state_d = ERR;
          err_d   = 1'b1;
          tmo_d   = 1'b0;
          idle_d  = '0;
        end else if (legal) begin
          state_d = RUN;
          tmo_d   = 1'b0;
          idle_d  = '0;
          if (S)      q_d = 1'b1;
          else if (R) q_d = 1'b0;
        end else if (state_q == RUN) begin
          // saturating idle count; TMO entered on the edge the limit is reached
          if (idle_q != TMO_LIM) idle_d = idle_q + 8'd1;
          if (idle_q + 8'd1 == TMO_LIM) begin
            state_d = TMO;
            tmo_d   = 1'b1;
          end
        end
      end
      ERR: begin
        tmo_d = 1'b0;
        // an illegal strobe coinciding with clr_err keeps the trap armed
        if (clr_err && !illegal) begin
          state_d = IDLE;
          err_d   = 1'b0;
          idle_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      state_q     <= IDLE;
      q_q         <= 1'b0;
      pulse_cnt_q <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      idle_q      <= '0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      q_q         <= q_d;
      pulse_cnt_q <= pulse_cnt_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      idle_q      <= idle_d;
    end
  end

  assign Q           = q_q;
  assign Qbar        = ~q_q;
  assign pulse_cnt   = pulse_cnt_q;
  assign err_illegal = err_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_sr_pulse_decoder.sv
// Directed bench for sr_pulse_decoder (SYNC_STAGES=2, TIMEOUT=16, CNT_W=8).
module tb_sr_pulse_decoder;
  logic       clk = 1'b0;
  logic       rst, ppulse, S, R, clr_err;
  logic       Q, Qbar, err_illegal, timeout;
  logic [7:0] pulse_cnt;
  int         vecs = 0;
  int         errs = 0;

  sr_pulse_decoder #(.SYNC_STAGES(2), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ppulse(ppulse), .S(S), .R(R), .clr_err(clr_err),
    .Q(Q), .Qbar(Qbar), .pulse_cnt(pulse_cnt), .err_illegal(err_illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // one high phase of hi cycles, then 3 low cycles; S/R held for the whole pulse
  task automatic send_pulse(input logic s, input logic r, input int hi);
    @(negedge clk); ppulse = 1'b1; S = s; R = r;
    repeat (hi) @(negedge clk);
    ppulse = 1'b0;
    repeat (3) @(negedge clk);
    S = 1'b0; R = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; ppulse = 1'b0; S = 1'b0; R = 1'b0; clr_err = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ppulse = 1'b0; S = 1'b0; R = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if ({Q, Qbar, pulse_cnt, err_illegal, timeout} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0}) begin
      errs++; $display("FAIL reset: got Q=%b Qbar=%b cnt=%0d err=%b tmo=%b", Q, Qbar, pulse_cnt, err_illegal, timeout); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clk); ppulse = 1'b1; S = 1'b1;
    @(negedge clk);  // edge k
    vecs++; if (Q !== 1'b0) begin errs++; $display("FAIL lat_k: Q=%b want 0", Q); end
    @(negedge clk);  // edge k+1
    vecs++; if (Q !== 1'b0) begin errs++; $display("FAIL lat_k1: Q=%b want 0", Q); end
    @(negedge clk);  // edge k+2
    vecs++; if ({Q, Qbar, pulse_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      errs++; $display("FAIL lat_k2: Q=%b Qbar=%b cnt=%0d want 1 0 1", Q, Qbar, pulse_cnt); end
    ppulse = 1'b0; S = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (pulse_cnt !== 8'd1) begin errs++; $display("FAIL lat_once: cnt=%0d want 1", pulse_cnt); end
  endtask

  task automatic test_commands();
    logic [1:0] sr_tab [3];
    logic       q_tab  [3];
    sr_tab = '{2'b01, 2'b00, 2'b10};
    q_tab  = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_pulse(sr_tab[i][1], sr_tab[i][0], 2 + i);
      vecs++; if (Q !== q_tab[i] || Qbar !== ~q_tab[i]) begin
        errs++; $display("FAIL cmd%0d: Q=%b Qbar=%b want Q=%b", i, Q, Qbar, q_tab[i]); end
    end
    vecs++; if (pulse_cnt !== 8'd3 || err_illegal !== 1'b0) begin
      errs++; $display("FAIL cmd_cnt: cnt=%0d err=%b want 3 0", pulse_cnt, err_illegal); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (20) @(negedge clk);
    vecs++; if (timeout !== 1'b0) begin errs++; $display("FAIL tmo_idle: tmo=%b want 0", timeout); end
    @(negedge clk); ppulse = 1'b1; S = 1'b1;
    @(negedge clk); ppulse = 1'b0;
    @(negedge clk);
    @(negedge clk); S = 1'b0;  // strobe edge passed, idle count 0
    vecs++; if (Q !== 1'b1) begin errs++; $display("FAIL tmo_set: Q=%b want 1", Q); end
    repeat (15) @(negedge clk);
    vecs++; if (timeout !== 1'b0) begin errs++; $display("FAIL tmo_15: tmo=%b want 0", timeout); end
    @(negedge clk);
    vecs++; if (timeout !== 1'b1) begin errs++; $display("FAIL tmo_16: tmo=%b want 1", timeout); end
    send_pulse(1'b0, 1'b1, 2);
    vecs++; if (timeout !== 1'b0 || Q !== 1'b0) begin
      errs++; $display("FAIL tmo_clear: tmo=%b Q=%b want 0 0", timeout, Q); end
  endtask

  task automatic test_illegal();
    do_reset();
    send_pulse(1'b1, 1'b0, 2);
    send_pulse(1'b1, 1'b1, 2);
    vecs++; if ({Q, err_illegal, pulse_cnt} !== {1'b1, 1'b1, 8'd2}) begin
      errs++; $display("FAIL ill_set: Q=%b err=%b cnt=%0d want 1 1 2", Q, err_illegal, pulse_cnt); end
    send_pulse(1'b0, 1'b1, 2);
    vecs++; if ({Q, pulse_cnt} !== {1'b1, 8'd3}) begin
      errs++; $display("FAIL ill_frozen: Q=%b cnt=%0d want 1 3", Q, pulse_cnt); end
    // clr_err only during the illegal strobe cycle
    @(negedge clk); ppulse = 1'b1; S = 1'b1; R = 1'b1;
    @(negedge clk); ppulse = 1'b0;
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0; S = 1'b0; R = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if ({err_illegal, pulse_cnt} !== {1'b1, 8'd4}) begin
      errs++; $display("FAIL ill_clr_coinc: err=%b cnt=%0d want 1 4", err_illegal, pulse_cnt); end
    repeat (30) @(negedge clk);
    vecs++; if (timeout !== 1'b0) begin errs++; $display("FAIL ill_tmo: tmo=%b want 0", timeout); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    vecs++; if (err_illegal !== 1'b0 || Q !== 1'b1) begin
      errs++; $display("FAIL ill_clr: err=%b Q=%b want 0 1", err_illegal, Q); end
    send_pulse(1'b0, 1'b1, 2);
    vecs++; if (Q !== 1'b0 || pulse_cnt !== 8'd5) begin
      errs++; $display("FAIL ill_resume: Q=%b cnt=%0d want 0 5", Q, pulse_cnt); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    send_pulse(1'b1, 1'b0, 1);
    vecs++; if (Q !== 1'b1 || err_illegal !== 1'b0) begin
      errs++; $display("FAIL clr_noeffect: Q=%b err=%b want 1 0", Q, err_illegal); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send_pulse(1'b0, 1'b0, 1);
    vecs++; if (pulse_cnt !== 8'd255) begin errs++; $display("FAIL wrap_255: cnt=%0d want 255", pulse_cnt); end
    send_pulse(1'b0, 1'b0, 1);
    vecs++; if (pulse_cnt !== 8'd0 || Q !== 1'b0) begin
      errs++; $display("FAIL wrap_0: cnt=%0d Q=%b want 0 0", pulse_cnt, Q); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) send_pulse(1'b1, 1'b0, 1);
    repeat (20) @(negedge clk);
    vecs++; if ({Q, pulse_cnt, timeout} !== {1'b1, 8'd5, 1'b1}) begin
      errs++; $display("FAIL pre_rst: Q=%b cnt=%0d tmo=%b want 1 5 1", Q, pulse_cnt, timeout); end
    #1 rst = 1'b1;
    #1;
    vecs++; if ({Q, Qbar, pulse_cnt, err_illegal, timeout} !== {1'b1 ^ 1'b1, 1'b1, 8'd0, 1'b0, 1'b0}) begin
      errs++; $display("FAIL async_rst: Q=%b Qbar=%b cnt=%0d err=%b tmo=%b", Q, Qbar, pulse_cnt, err_illegal, timeout); end
    // ppulse held high across release yields exactly one strobe
    ppulse = 1'b1; S = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (Q !== 1'b0) begin errs++; $display("FAIL rel_e2: Q=%b want 0", Q); end
    @(negedge clk);
    vecs++; if (Q !== 1'b1 || pulse_cnt !== 8'd1) begin
      errs++; $display("FAIL rel_e3: Q=%b cnt=%0d want 1 1", Q, pulse_cnt); end
    repeat (10) @(negedge clk);
    vecs++; if (pulse_cnt !== 8'd1) begin errs++; $display("FAIL rel_once: cnt=%0d want 1", pulse_cnt); end
    ppulse = 1'b0; S = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_commands();
    test_timeout();
    test_illegal();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vecs);
    $fatal(1, "watchdog");
  end
endmodule
